// File: rtl/wb_port_scheduler.sv
// Write-back port arbiter: merges execute results and in-order load returns onto the single
// register-file write port, tracking outstanding load destinations for the issue stall logic.
module wb_port_scheduler #(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_Q_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ex_valid,
    output logic                     ex_ready,
    input  logic                     ex_we,
    input  logic [1:0]               ex_sel,
    input  logic [REG_ADDR_W-1:0]    ex_rd,
    input  logic [XLEN-1:0]          ex_alu_result,
    input  logic [XLEN-1:0]          ex_pc_plus4,
    input  logic                     ld_issue_valid,
    input  logic [REG_ADDR_W-1:0]    ld_issue_rd,
    output logic                     ld_issue_ready,
    input  logic                     mem_rsp_valid,
    input  logic [XLEN-1:0]          mem_rsp_data,
    output logic                     rf_we,
    output logic [REG_ADDR_W-1:0]    rf_addr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic [2**REG_ADDR_W-1:0] busy_mask,
    output logic                     rsp_err
);
    localparam int NREG = 2**REG_ADDR_W;
    localparam int PW   = (LOAD_Q_DEPTH > 1) ? $clog2(LOAD_Q_DEPTH) : 1;
    localparam int CW   = $clog2(LOAD_Q_DEPTH) + 1;

    logic [REG_ADDR_W-1:0] r_q [LOAD_Q_DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;

    logic                  r_rf_we;
    logic [REG_ADDR_W-1:0] r_rf_addr;
    logic [XLEN-1:0]       r_rf_wdata;
    logic                  r_rsp_err;

    logic                  w_nonempty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_ex_wr;
    logic [REG_ADDR_W-1:0] w_head_rd;

    // Explicit wrap keeps non-power-of-two-free depths (including 1) safe.
    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(LOAD_Q_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_nonempty     = (r_count != '0);
    assign w_pop          = mem_rsp_valid && w_nonempty;
    // A response in the same cycle frees a slot, so a full queue may still take a push.
    assign ld_issue_ready = (r_count < CW'(LOAD_Q_DEPTH)) || mem_rsp_valid;
    assign w_push         = ld_issue_valid && ld_issue_ready;
    assign w_head_rd      = r_q[r_head];

    // Load returns own the port; also stall any write to a register with a load in flight.
    assign ex_ready = ex_valid && !(ex_we && w_pop) && !(ex_we && busy_mask[ex_rd]);
    assign w_ex_wr  = ex_valid && ex_ready && ex_we;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q[r_tail] <= ld_issue_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= f_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= f_inc(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Per-register occupancy counters; x0 is never reported busy.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_mask[gi] = 1'b0;
            end else begin : g_cnt
                logic [CW-1:0] r_cnt;
                logic          w_inc;
                logic          w_dec;

                assign w_inc = w_push && (ld_issue_rd == REG_ADDR_W'(gi));
                assign w_dec = w_pop && (w_head_rd == REG_ADDR_W'(gi));

                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_cnt <= '0;
                    end else if (w_inc && !w_dec) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (!w_inc && w_dec) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                assign busy_mask[gi] = (r_cnt != '0);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rf_we    <= 1'b0;
            r_rf_addr  <= '0;
            r_rf_wdata <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_rf_we <= 1'b0;
            if (w_pop) begin
                r_rf_we    <= (w_head_rd != '0);
                r_rf_addr  <= w_head_rd;
                r_rf_wdata <= mem_rsp_data;
            end else if (w_ex_wr) begin
                r_rf_we    <= (ex_rd != '0);
                r_rf_addr  <= ex_rd;
                r_rf_wdata <= (ex_sel == 2'd2) ? ex_pc_plus4 : ex_alu_result;
            end
            if (mem_rsp_valid && !w_nonempty) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_addr  = r_rf_addr;
    assign rf_wdata = r_rf_wdata;
    assign rsp_err  = r_rsp_err;
endmodule
